// File: rtl/instruction_reg_if.sv
// ---------------------------------------------------------------------------
// instruction_reg_if
//
// Purpose:
//     Bundles the instruction-register datapath signals into one connection.
//     The fetch side drives the raw instruction word. The decode side sees the
//     three fields split out of the held instruction.
//
// Signals:
//     instr_in  - fetched instruction word (INSTR_W bits)
//     opcode    - opcode field of the held instruction (OPC_W bits)
//     addr_Rz   - destination-register address field (REG_W bits)
//     src_imm   - source-operand / immediate / address field (IMM_W bits)
//
// Modports:
//     master - fetch/test side: drives instr_in and observes the fields
//     slave  - instruction register: consumes instr_in and drives the fields
// ---------------------------------------------------------------------------
interface instruction_reg_if #(
    parameter int INSTR_W = 24,
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 16
) ();

    logic [INSTR_W-1:0] instr_in;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   addr_Rz;
    logic [IMM_W-1:0]   src_imm;

    modport master (
        output instr_in,
        input  opcode,
        input  addr_Rz,
        input  src_imm
    );

    modport slave (
        input  instr_in,
        output opcode,
        output addr_Rz,
        output src_imm
    );

endinterface

// File: rtl/instruction_reg.sv
// ---------------------------------------------------------------------------
// instruction_reg
//
// Purpose:
//     Holds one fetched instruction word (IR). It captures the word on every
//     rising clock edge and presents the opcode, destination register and
//     source/immediate fields as plain slices of the held word.
//
// Ports:
//     clk    - single clock; all state changes on its rising edge
//     reset  - synchronous, active-high; clears IR to zero
//     bus    - instruction_reg_if.slave
//                instr_in (in)  : fetched instruction word
//                opcode   (out) : IR[INSTR_W-1 -: OPC_W]
//                addr_Rz  (out) : next REG_W bits below the opcode
//                src_imm  (out) : IR[IMM_W-1:0]
//
// Parameters must satisfy OPC_W + REG_W + IMM_W == INSTR_W. Other
// combinations are unsupported, and the field slices would overlap or
// leave gaps. The interface instance must use the same parameter values.
// ---------------------------------------------------------------------------
module instruction_reg #(
    parameter int INSTR_W = 24,
    parameter int OPC_W   = 4,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    instruction_reg_if.slave   bus
);

    logic [INSTR_W-1:0] ir_d;
    logic [INSTR_W-1:0] ir_q;

    // The register loads every cycle. There is no enable, so the next
    // value is always the word currently on the bus.
    always_comb begin
        ir_d = bus.instr_in;
    end

    // Reset takes priority over capture, so instr_in is ignored on a
    // reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    // The outputs are driven only from ir_q. This keeps them free of any
    // combinational path from instr_in, so they stay stable between edges.
    assign bus.opcode  = ir_q[INSTR_W-1 -: OPC_W];
    assign bus.addr_Rz = ir_q[INSTR_W-OPC_W-1 -: REG_W];
    assign bus.src_imm = ir_q[IMM_W-1:0];

endmodule

// File: tb/tb_instruction_reg.sv
// ---------------------------------------------------------------------------
// tb_instruction_reg
//
// Directed bench for instruction_reg. Stimulus is driven on the falling edge.
// The expected IR contents are pushed onto a scoreboard queue at that point.
// They are popped and compared #1 after the following rising edge. Between
// edges, the outputs are also compared against the last popped word, which
// shows they ignore instr_in activity.
// ---------------------------------------------------------------------------
module tb_instruction_reg;

    localparam int INSTR_W = 24;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 16;

    logic clk;
    logic reset;

    instruction_reg_if #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W), .IMM_W(IMM_W)
    ) bus ();

    instruction_reg #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_W(REG_W), .IMM_W(IMM_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [INSTR_W-1:0] exp_q[$];
    logic [INSTR_W-1:0] held_word;

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares each output field against the fields of the expected IR word.
    task automatic checkOutput(input string tag, input logic [INSTR_W-1:0] exp_word);
        logic [OPC_W-1:0] e_opc;
        logic [REG_W-1:0] e_rz;
        logic [IMM_W-1:0] e_imm;
        e_opc = exp_word[23:20];
        e_rz  = exp_word[19:16];
        e_imm = exp_word[15:0];
        vectors++;
        assert (bus.opcode === e_opc) else begin
            miscompares++;
            $error("[TB] FAIL %s opcode: got 0x%0h, expected 0x%0h", tag, bus.opcode, e_opc);
        end
        vectors++;
        assert (bus.addr_Rz === e_rz) else begin
            miscompares++;
            $error("[TB] FAIL %s addr_Rz: got 0x%0h, expected 0x%0h", tag, bus.addr_Rz, e_rz);
        end
        vectors++;
        assert (bus.src_imm === e_imm) else begin
            miscompares++;
            $error("[TB] FAIL %s src_imm: got 0x%0h, expected 0x%0h", tag, bus.src_imm, e_imm);
        end
    endtask

    // Drives reset and instr_in on the falling edge and records the
    // expected IR value: zero on a reset edge, otherwise the word itself.
    task automatic applyStimulus(input logic rst, input logic [INSTR_W-1:0] word);
        @(negedge clk);
        reset       = rst;
        bus.instr_in = word;
        exp_q.push_back(rst ? '0 : word);
    endtask

    // Waits for the capturing edge, then pops and checks one expectation.
    task automatic captureAndCheck(input string tag);
        @(posedge clk);
        #1;
        vectors++;
        assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("[TB] FAIL %s scoreboard: got empty queue, expected pending entry", tag);
        end
        if (exp_q.size() > 0) begin
            held_word = exp_q.pop_front();
            checkOutput(tag, held_word);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.instr_in = 24'hFFFFFF;
        held_word    = '0;

        // Two reset edges with all-ones on the bus must leave IR cleared.
        applyStimulus(1'b1, 24'hFFFFFF);
        captureAndCheck("reset_edge1");
        applyStimulus(1'b1, 24'hFFFFFF);
        captureAndCheck("reset_edge2");

        // First capture after reset release.
        applyStimulus(1'b0, 24'hC10005);
        captureAndCheck("mvi_r1");

        // The previous value holds until the capturing edge.
        applyStimulus(1'b0, 24'hD20004);
        #1;
        checkOutput("load_hold_prev", held_word);
        captureAndCheck("load_r2");

        applyStimulus(1'b0, 24'h131200);
        captureAndCheck("add_r3");

        // Mid-stream reset discards the held word, and the next edge
        // captures normally.
        applyStimulus(1'b1, 24'hABCDEF);
        captureAndCheck("midstream_reset");
        applyStimulus(1'b0, 24'hABCDEF);
        captureAndCheck("post_reset_load");

        // instr_in toggles between edges, and only the value at the edge counts.
        applyStimulus(1'b0, 24'h123456);
        #1;
        checkOutput("between_edges_a", held_word);
        #2;
        bus.instr_in = 24'h654321;
        void'(exp_q.pop_back());
        exp_q.push_back(24'h654321);
        #1;
        checkOutput("between_edges_b", held_word);
        captureAndCheck("late_change");

        // The same word on consecutive cycles keeps the outputs steady.
        applyStimulus(1'b0, 24'h5A5A5A);
        captureAndCheck("repeat_1");
        applyStimulus(1'b0, 24'h5A5A5A);
        #1;
        checkOutput("repeat_mid", held_word);
        captureAndCheck("repeat_2");

        // Random words for bit-exact field extraction.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, INSTR_W'($urandom));
            captureAndCheck("random");
        end

        // All-ones word gives no sign-extension or masking effects.
        applyStimulus(1'b0, 24'hFFFFFF);
        captureAndCheck("all_ones");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
